// File: rtl/mem_ref_sequencer.sv
// Control sequencer for memory-reference instructions (AND..ISZ).
// Walks IDLE -> [IND] -> E4 -> [E5] -> [E6] and emits registered strobes.
module mem_ref_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] ir,
    input  logic             dr_zero,
    output logic [2:0]       bus_sel,
    output logic             ar_ld,
    output logic             ar_inr,
    output logic             pc_ld,
    output logic             pc_inr,
    output logic             dr_ld,
    output logic             dr_inr,
    output logic             ac_ld,
    output logic             mem_wr,
    output logic [2:0]       alu_op,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        IND  = 3'd1,
        E4   = 3'd2,
        E5   = 3'd3,
        E6   = 3'd4
    } state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_LDA = 3'b010;
    localparam logic [2:0] OP_STA = 3'b011;
    localparam logic [2:0] OP_BUN = 3'b100;
    localparam logic [2:0] OP_BSA = 3'b101;
    localparam logic [2:0] OP_ISZ = 3'b110;
    localparam logic [2:0] OP_REG = 3'b111;

    localparam logic [2:0] BUS_NONE = 3'b000;
    localparam logic [2:0] BUS_PC   = 3'b001;
    localparam logic [2:0] BUS_AR   = 3'b010;
    localparam logic [2:0] BUS_DR   = 3'b011;
    localparam logic [2:0] BUS_AC   = 3'b101;
    localparam logic [2:0] BUS_MEM  = 3'b110;

    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_AND  = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_DR   = 3'b011;

    typedef struct packed {
        logic [2:0] bus_sel;
        logic       ar_ld;
        logic       ar_inr;
        logic       pc_ld;
        logic       pc_inr_en;
        logic       dr_ld;
        logic       dr_inr;
        logic       ac_ld;
        logic       mem_wr;
        logic [2:0] alu_op;
        logic       done;
    } ctl_t;

    function automatic state_t next_state(
        input state_t     s,
        input logic       go,
        input logic       ind_new,
        input logic       ind_old,
        input logic [2:0] op
    );
        state_t n;
        n = IDLE;
        case (s)
            IDLE: begin
                if (go) n = ind_new ? IND : E4;
            end
            IND: n = ind_old ? E4 : IDLE;
            E4: begin
                if (op == OP_STA || op == OP_BUN) n = IDLE;
                else n = E5;
            end
            E5: n = (op == OP_ISZ) ? E6 : IDLE;
            E6: n = IDLE;
            default: n = IDLE;
        endcase
        return n;
    endfunction

    function automatic ctl_t decode(input state_t s, input logic [2:0] op);
        ctl_t c;
        c = '0;
        case (s)
            IND: begin
                c.bus_sel = BUS_MEM;
                c.ar_ld   = 1'b1;
            end
            E4: begin
                case (op)
                    OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                        c.bus_sel = BUS_MEM;
                        c.dr_ld   = 1'b1;
                    end
                    OP_STA: begin
                        c.bus_sel = BUS_AC;
                        c.mem_wr  = 1'b1;
                        c.done    = 1'b1;
                    end
                    OP_BUN: begin
                        c.bus_sel = BUS_AR;
                        c.pc_ld   = 1'b1;
                        c.done    = 1'b1;
                    end
                    OP_BSA: begin
                        c.bus_sel = BUS_PC;
                        c.mem_wr  = 1'b1;
                        c.ar_inr  = 1'b1;
                    end
                    default: c = '0;
                endcase
            end
            E5: begin
                case (op)
                    OP_AND: begin
                        c.ac_ld  = 1'b1;
                        c.alu_op = ALU_AND;
                        c.done   = 1'b1;
                    end
                    OP_ADD: begin
                        c.ac_ld  = 1'b1;
                        c.alu_op = ALU_ADD;
                        c.done   = 1'b1;
                    end
                    OP_LDA: begin
                        c.ac_ld  = 1'b1;
                        c.alu_op = ALU_DR;
                        c.done   = 1'b1;
                    end
                    OP_BSA: begin
                        c.bus_sel = BUS_AR;
                        c.pc_ld   = 1'b1;
                        c.done    = 1'b1;
                    end
                    OP_ISZ: c.dr_inr = 1'b1;
                    default: c = '0;
                endcase
            end
            E6: begin
                c.bus_sel   = BUS_DR;
                c.mem_wr    = 1'b1;
                c.pc_inr_en = 1'b1;
                c.done      = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t     state;
    state_t     state_d;
    logic [2:0] op_q;
    logic [2:0] op_d;
    logic       ind_q;
    logic       accept;
    logic       busy_q;
    ctl_t       ctl;
    logic       unused_ir;

    assign unused_ir = ^ir;

    always_comb begin
        accept  = (state == IDLE) && start && (ir[14:12] != OP_REG);
        op_d    = accept ? ir[14:12] : op_q;
        state_d = next_state(state, accept, ir[15], ind_q, op_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= '0;
            ind_q  <= 1'b0;
            busy_q <= 1'b0;
            ctl    <= '0;
        end else begin
            state  <= state_d;
            op_q   <= op_d;
            if (accept) ind_q <= ir[15];
            busy_q <= (state_d != IDLE);
            ctl    <= decode(state_d, op_d);
        end
    end

    // Skip decision must follow DR as seen during E6 itself, so it is gated live.
    assign pc_inr  = ctl.pc_inr_en & dr_zero;
    assign bus_sel = ctl.bus_sel;
    assign ar_ld   = ctl.ar_ld;
    assign ar_inr  = ctl.ar_inr;
    assign pc_ld   = ctl.pc_ld;
    assign dr_ld   = ctl.dr_ld;
    assign dr_inr  = ctl.dr_inr;
    assign ac_ld   = ctl.ac_ld;
    assign mem_wr  = ctl.mem_wr;
    assign alu_op  = ctl.alu_op;
    assign done    = ctl.done;
    assign busy    = busy_q;

endmodule

// File: doc/mem_ref_sequencer.md
MEM_REF_SEQUENCER -- requirements
Module: mem_ref_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning instruction register width.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request from fetch control to execute a memory-reference instruction.
REQ-005 SHALL have port ir  input  WIDTH  current instruction: bit 15 = I, bits 14-12 = opcode.
REQ-006 SHALL have port dr_zero  input  1  high when DR equals zero.
REQ-007 SHALL have port bus_sel  output  3  bus source: 000 none, 001 PC, 010 AR, 011 DR, 100 IR, 101 AC, 110 MEM.
REQ-008 SHALL have ports ar_ld, ar_inr, pc_ld, pc_inr, dr_ld, dr_inr, ac_ld, mem_wr  output  1 each  register load/increment strobes and memory write.
REQ-009 SHALL have port alu_op  output  3  000 none, 001 AND, 010 ADD, 011 pass DR.
REQ-010 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-011 SHALL have port done  output  1  one-cycle pulse in the final control cycle; used to clear the sequence counter.

Function
REQ-012 SHALL latch opcode and I on the rising edge where start=1 in IDLE, and opcode != 111.
REQ-013 SHALL ignore start while busy=1 and when opcode=111 (no state change, no outputs).
REQ-014 SHALL implement states IDLE, IND, E4, E5, E6; outputs are decoded from state and latched opcode only (Moore).
REQ-015 SHALL go IDLE->IND when I=1, IDLE->E4 when I=0.
REQ-016 IND SHALL drive bus_sel=110, ar_ld=1 (AR<-M[AR]), then go to E4.
REQ-017 AND/ADD/LDA (000/001/010): E4 bus_sel=110, dr_ld=1; E5 ac_ld=1, alu_op=001/010/011 respectively, done=1.
REQ-018 STA (011): E4 bus_sel=101, mem_wr=1, done=1.
REQ-019 BUN (100): E4 bus_sel=010, pc_ld=1, done=1.
REQ-020 BSA (101): E4 bus_sel=001, mem_wr=1, ar_inr=1; E5 bus_sel=010, pc_ld=1, done=1.
REQ-021 ISZ (110): E4 bus_sel=110, dr_ld=1; E5 dr_inr=1; E6 bus_sel=011, mem_wr=1, pc_inr=dr_zero, done=1.
REQ-022 After the done cycle the SHALL return to IDLE next edge; busy deasserts in that IDLE cycle.
REQ-023 Latency from start edge to done cycle SHALL be (states listed above) plus 1 if I=1: STA/BUN 1(2), AND/ADD/LDA/BSA 2(3), ISZ 3(4) cycles.
REQ-024 In IDLE all outputs SHALL be 0 and bus_sel=000.
REQ-025 SHALL never assert more than one of pc_ld/pc_inr, or more than one of ar_ld/ar_inr, in a cycle.
REQ-026 A start coincident with done SHALL be ignored; a new start is accepted only in IDLE.
REQ-027 dr_zero SHALL be sampled only in E6; its value in other states has no effect.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, clear latched opcode/I, and drive all outputs 0 independent of clk.
REQ-029 rst asserted mid-instruction SHALL abort it with no further strobes; after release, the sequencer waits for a fresh start.

Verification
REQ-030 Direct LDA: ir=0x2005, start pulse -> E4: bus_sel=110, dr_ld; next cycle ac_ld, alu_op=011, done; then IDLE.
REQ-031 Indirect ADD: ir=0x9010 -> IND (ar_ld, bus_sel=110), E4 (dr_ld), E5 (alu_op=010, ac_ld, done); 3 control cycles.
REQ-032 ISZ with dr_zero=1 in E6: ir=0x6020 -> E6 shows mem_wr, bus_sel=011, pc_inr=1, done; repeat with dr_zero=0 -> pc_inr=0.
REQ-033 BSA: ir=0x5030 -> E4 mem_wr, bus_sel=001, ar_inr; E5 pc_ld, bus_sel=010, done.
REQ-034 Start ignored: ir=0x7800 start -> no busy, no strobes; start pulsed during ISZ E5 -> ISZ completes unchanged, no second run.
REQ-035 Reset mid-op: ir=0xE040 start, rst asserted during E5 -> all outputs 0 immediately, busy=0; after release no strobes until next start.
